blink_checker: RTL and testbench
================================

// Module: blink_checker
// PURPOSE
//  Receive-side monitor for the blink LED output: samples the blinking signal,
//  measures every high/low phase in clk cycles and checks it against the
//  expected half-period. Asserts lock after consecutive good phases.
//  Flags out-of-tolerance phases and a stuck (non-toggling) signal.
//  Sits beside blink in the same clock domain, for on-chip self-check and bench.
// PARAMETERS
//  HALF_PERIOD  50   expected phase length in clk cycles
//  TOL          2    accepted deviation, +/- cycles (inclusive)
//  LOCK_COUNT   4    consecutive good phases needed to lock (>=1)
//  TIMEOUT      200  cycles without an edge before stuck (> HALF_PERIOD+TOL)
//  CW           16   width of the phase counter, len and edges
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  q_in       in   1   blink output under test; synchronous to clk
//  locked     out  1   LOCK_COUNT consecutive good phases seen, none bad since
//  stuck      out  1   no edge for TIMEOUT cycles; held until next edge
//  bad_len    out  1   1-cycle pulse: measured phase outside tolerance
//  len_valid  out  1   1-cycle pulse: len holds a new complete phase length
//  len        out  CW  last complete phase length in cycles
//  edges      out  CW  total edges seen since reset, saturating at 2^CW-1
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): all outputs 0; state=IDLE; cnt=0; good_run=0;
//   armed=0; q_d<=q_in. Reset mid-operation aborts the current measurement.
//  Edge detect: q_d<=q_in every cycle; armed<=1 on the first cycle after reset.
//   edge = armed & (q_in != q_d). So a q_in level at reset never makes an edge.
//  Phase counter cnt: on edge, cnt<=1; otherwise cnt<=cnt+1, saturating at
//   2^CW-1. At an edge, cnt = cycles since the previous edge.
//   Toggle every 50 cycles -> cnt=50 at each edge.
//  good = (cnt >= HALF_PERIOD-TOL) && (cnt <= HALF_PERIOD+TOL); compare unsigned,
//   lower bound clamps at 0.
//  Outputs are registered; they update at the clk edge that samples the q_in edge.
//   Latency: 1 cycle from q_in change to len_valid/bad_len/locked.
//  edges increments on every edge in every state.
//  FSM (state, good_run 0..LOCK_COUNT):
//   IDLE:   edge -> ACQ, good_run=0; no len_valid (first phase is partial).
//           cnt==TIMEOUT and no edge -> STUCK.
//   ACQ:    edge: len<=cnt, len_valid=1.
//           good: good_run+1; if it reaches LOCK_COUNT -> LOCKED, locked=1.
//           bad:  bad_len=1, good_run=0, stay ACQ.
//           cnt==TIMEOUT and no edge -> STUCK.
//   LOCKED: edge: len<=cnt, len_valid=1.
//           good: stay LOCKED.
//           bad:  bad_len=1, locked=0, good_run=0 -> ACQ.
//           cnt==TIMEOUT and no edge -> STUCK, locked=0.
//   STUCK:  stuck=1, locked=0. edge -> ACQ, stuck=0, good_run=0, no len_valid
//           (phase length is meaningless after a timeout).
//  Edge and cnt==TIMEOUT in the same cycle: the edge wins; no stuck.
//  len holds its value between len_valid pulses. bad_len never fires without
//   len_valid in the same cycle.
// TESTING
//  T1 reset, q_in toggles every 50 cycles -> len_valid per edge with len=50,
//     bad_len=0; locked rises 1 cycle after 5th edge; edges=5 at that point.
//  T2 locked, one phase of 53 cycles -> len=53, len_valid=1, bad_len=1 same
//     cycle, locked=0; 4 further 50-cycle phases -> locked=1 again.
//  T3 phases of 48 and 52 -> good, no bad_len; phase of 47 -> bad_len=1;
//     phase of 53 -> bad_len=1.
//  T4 locked, q_in held 200 cycles after last edge -> stuck=1, locked=0 exactly
//     when cnt==200; next edge -> stuck=0, no len_valid, state ACQ.
//  T5 rst for 1 cycle while locked with q_in=1, q_in then constant -> all
//     outputs 0 next cycle; no edge counted; stuck after 200 cycles from IDLE.
//  T6 toggle exactly at cnt==TIMEOUT -> no stuck; len=200, bad_len=1.

Source files
------------

// File: rtl/blink_checker.sv
// blink_checker: receive-side monitor for a blinking signal.
// Measures every high/low phase in clk cycles, checks it against the expected
// half-period, tracks lock after consecutive good phases and flags a stuck line.
module blink_checker #(
  parameter int HALF_PERIOD = 50,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 200,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          q_in,
  output logic          locked,
  output logic          stuck,
  output logic          bad_len,
  output logic          len_valid,
  output logic [CW-1:0] len,
  output logic [CW-1:0] edges
);

  // Bounds of the accepted window; the lower bound clamps at zero.
  localparam int LO = (HALF_PERIOD > TOL) ? HALF_PERIOD - TOL : 0;
  localparam int HI = HALF_PERIOD + TOL;
  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [CW-1:0] LO_C = CW'(LO);
  localparam logic [CW-1:0] HI_C = CW'(HI);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
  localparam logic [GW-1:0] LAST = GW'(LOCK_COUNT - 1);
  localparam logic [GW-1:0] FULL = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, STUCK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] good_run;
  logic          armed;
  logic          q_d;

  logic edge_seen;
  logic good;
  logic timeout;

  // The first cycle after reset is never an edge, whatever level q_in held.
  assign edge_seen = armed & (q_in != q_d);
  // cnt at an edge is the length of the phase that just ended.
  assign good      = (cnt >= LO_C) && (cnt <= HI_C);
  // An edge in the timeout cycle takes priority over declaring stuck.
  assign timeout   = (cnt == TO_C) && !edge_seen;

  // Edge detect, phase counter, edge counter and lock/stuck FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      good_run  <= '0;
      armed     <= 1'b0;
      q_d       <= q_in;
      locked    <= 1'b0;
      stuck     <= 1'b0;
      bad_len   <= 1'b0;
      len_valid <= 1'b0;
      len       <= '0;
      edges     <= '0;
    end else begin
      q_d       <= q_in;
      armed     <= 1'b1;
      len_valid <= 1'b0;
      bad_len   <= 1'b0;

      if (edge_seen)        cnt <= CW'(1);
      else if (cnt != CMAX) cnt <= cnt + CW'(1);

      if (edge_seen && edges != CMAX) edges <= edges + CW'(1);

      case (state)
        IDLE: begin
          // First phase after reset is partial, so it is not reported.
          if (edge_seen) begin
            state    <= ACQ;
            good_run <= '0;
          end else if (timeout) begin
            state <= STUCK;
            stuck <= 1'b1;
          end
        end
        ACQ: begin
          if (edge_seen) begin
            len       <= cnt;
            len_valid <= 1'b1;
            if (good) begin
              if (good_run == LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_run <= FULL;
              end else begin
                good_run <= good_run + GW'(1);
              end
            end else begin
              bad_len  <= 1'b1;
              good_run <= '0;
            end
          end else if (timeout) begin
            state  <= STUCK;
            stuck  <= 1'b1;
            locked <= 1'b0;
          end
        end
        LOCKED: begin
          if (edge_seen) begin
            len       <= cnt;
            len_valid <= 1'b1;
            if (!good) begin
              bad_len  <= 1'b1;
              locked   <= 1'b0;
              good_run <= '0;
              state    <= ACQ;
            end
          end else if (timeout) begin
            state  <= STUCK;
            stuck  <= 1'b1;
            locked <= 1'b0;
          end
        end
        STUCK: begin
          // Phase length after a timeout is meaningless, so no len_valid.
          locked <= 1'b0;
          if (edge_seen) begin
            state    <= ACQ;
            stuck    <= 1'b0;
            good_run <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_checker.sv
// Bench for blink_checker: expected phase reports are queued when an edge is
// driven and compared when the DUT should report it.
module tb_blink_checker;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          q_in;
  logic          locked, stuck, bad_len, len_valid;
  logic [CW-1:0] len, edges;

  blink_checker #(.HALF_PERIOD(50), .TOL(2), .LOCK_COUNT(4), .TIMEOUT(200), .CW(CW)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .locked(locked), .stuck(stuck),
    .bad_len(bad_len), .len_valid(len_valid), .len(len), .edges(edges)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int len; bit bad; bit lk;} exp_t;
  exp_t sb[$];
  exp_t e;

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  int tflip = 0;
  int trst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Toggle q_in n cycles after the previous toggle; optionally queue the report.
  task automatic phase(input int n, input bit push, input bit bad, input bit lk);
    wait_to(tflip + n);
    q_in  = ~q_in;
    tflip = cyc;
    if (push) sb.push_back('{cyc + 1, n, bad, lk});
  endtask

  // Scoreboard: report expected exactly one cycle after each driven edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("len_valid", len_valid, 1);
      chk("len", len, e.len);
      chk("bad_len", bad_len, e.bad);
      chk("locked", locked, e.lk);
    end else begin
      chk("quiet", {len_valid, bad_len}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    q_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tflip = cyc;
    chk("rst_out", {locked, stuck, bad_len, len_valid}, 0);
    chk("rst_len", len, 0);
    chk("rst_edges", edges, 0);

    // T1: steady 50-cycle toggling, lock after the 5th edge.
    phase(50, 0, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 1);
    wait_to(tflip + 1);
    chk("t1_edges", edges, 5);
    chk("t1_lock", locked, 1);

    // T2: one long phase breaks lock, four good phases regain it.
    phase(53, 1, 1, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 1);

    // T3: tolerance edges.
    phase(48, 1, 0, 1);
    phase(52, 1, 0, 1);
    phase(47, 1, 1, 0);
    phase(53, 1, 1, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 1);

    // T4: line held; stuck exactly when cnt reaches 200.
    wait_to(tflip + 200);
    chk("t4_pre_stuck", stuck, 0);
    chk("t4_pre_lock", locked, 1);
    wait_to(tflip + 201);
    chk("t4_stuck", stuck, 1);
    chk("t4_unlock", locked, 0);
    phase(240, 0, 0, 0);
    wait_to(tflip + 1);
    chk("t4_unstuck", stuck, 0);
    chk("t4_edges", edges, 19);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 0);
    phase(50, 1, 0, 1);
    wait_to(tflip + 5);
    chk("t4_relock", locked, 1);

    // T5: reset while locked, q_in forced high and then constant.
    rst = 1'b1;
    q_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    trst = cyc;
    chk("t5_out", {locked, stuck, bad_len, len_valid}, 0);
    chk("t5_len", len, 0);
    chk("t5_edges", edges, 0);
    wait_to(trst + 200);
    chk("t5_pre_stuck", stuck, 0);
    wait_to(trst + 201);
    chk("t5_stuck", stuck, 1);
    chk("t5_no_edge", edges, 0);

    // T6: toggle exactly at the timeout count.
    tflip = cyc;
    phase(5, 0, 0, 0);
    wait_to(tflip + 1);
    chk("t6_unstuck", stuck, 0);
    phase(200, 1, 1, 0);
    wait_to(tflip + 1);
    chk("t6_no_stuck", stuck, 0);
    wait_to(tflip + 3);
    chk("t6_edges", edges, 2);

    chk("drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
